// File: rtl/m_m_game_pkg.sv
// m_m_game_pkg: shared types and constants for the counter-game match logic.
// Mode/who encodings and the round config record used by sequencer and table.
package m_m_game_pkg;

   localparam int N_ROUNDS   = 4;
   localparam int WIN_TARGET = 3;
   localparam int TIMEOUT    = 255;

   localparam logic [1:0] WHO_A = 2'b01;
   localparam logic [1:0] WHO_B = 2'b10;

   typedef enum logic [1:0] {
      UP1,
      UP2,
      DN1,
      DN2
   } mode_t;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      LOAD,
      RUN,
      TALLY,
      DONE
   } state_t;

   typedef struct packed {
      mode_t      mode;
      logic [2:0] val;
   } round_cfg_t;

   function automatic logic [2:0] sat_inc(input logic [2:0] s);
      return (s == 3'd7) ? s : s + 3'd1;
   endfunction

endpackage

// File: rtl/m_m_round_table.sv
// m_m_round_table: per-round config register file.
// One synchronous write port, one combinational read port, cleared on reset.
module m_m_round_table
   import m_m_game_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       we_i,
   input  logic [1:0] widx_i,
   input  round_cfg_t wdata_i,
   input  logic [1:0] ridx_i,
   output round_cfg_t rdata_o
);

   round_cfg_t mem_q [N_ROUNDS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_ROUNDS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[widx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/m_m_round_sched.sv
// m_m_round_sched: match sequencer for the multi-mode counter game.
// Plays configured rounds on the counter, tallies wins, declares the winner.
module m_m_round_sched
   import m_m_game_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       cfg_we,
   input  logic [1:0] cfg_idx,
   input  logic [1:0] cfg_mode,
   input  logic [2:0] cfg_val,
   output logic       cnt_reset,
   output logic       cnt_init,
   output logic [1:0] cnt_ctrl,
   output logic [2:0] cnt_val,
   input  logic       gameover,
   input  logic [1:0] who,
   output logic       busy,
   output logic [1:0] round_no,
   output logic [2:0] score_a,
   output logic [2:0] score_b,
   output logic       match_done,
   output logic [1:0] match_winner
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [2:0] WIN      = 3'(WIN_TARGET);
   localparam logic [1:0] LAST_RND = 2'(N_ROUNDS - 1);

   state_t     state_q;
   logic       cnt_reset_q, cnt_init_q, busy_q, done_q;
   logic [1:0] ctrl_q, round_q, who_q, winner_q;
   logic [2:0] val_q, sa_q, sb_q;
   logic [7:0] tmo_q;

   logic       tbl_we, end_d;
   logic [2:0] sa_d, sb_d;
   logic [1:0] winner_d;
   round_cfg_t wr_cfg, rd_cfg;

   // Table is only writable between matches; a same-cycle start sees the write.
   assign tbl_we = cfg_we && (state_q == IDLE);
   assign wr_cfg = '{mode: mode_t'(cfg_mode), val: cfg_val};

   m_m_round_table u_table (
      .clk     (clk),
      .reset   (reset),
      .we_i    (tbl_we),
      .widx_i  (cfg_idx),
      .wdata_i (wr_cfg),
      .ridx_i  (round_q),
      .rdata_o (rd_cfg)
   );

   always_comb begin
      sa_d = (who_q == WHO_A) ? sat_inc(sa_q) : sa_q;
      sb_d = (who_q == WHO_B) ? sat_inc(sb_q) : sb_q;
      end_d = (sa_d == WIN) || (sb_d == WIN) || (round_q == LAST_RND);
      if (sa_d > sb_d) begin
         winner_d = WHO_A;
      end else if (sb_d > sa_d) begin
         winner_d = WHO_B;
      end else begin
         winner_d = 2'b11;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_reset_q <= 1'b1;
         cnt_init_q  <= 1'b0;
         ctrl_q      <= 2'b00;
         val_q       <= 3'b000;
         busy_q      <= 1'b0;
         round_q     <= 2'd0;
         sa_q        <= 3'd0;
         sb_q        <= 3'd0;
         done_q      <= 1'b0;
         winner_q    <= 2'b00;
         who_q       <= 2'b00;
         tmo_q       <= 8'd0;
      end else begin
         cnt_init_q <= 1'b0;
         done_q     <= 1'b0;
         unique case (state_q)
            IDLE: begin
               cnt_reset_q <= 1'b1;
               if (start) begin
                  state_q  <= CLR;
                  busy_q   <= 1'b1;
                  sa_q     <= 3'd0;
                  sb_q     <= 3'd0;
                  round_q  <= 2'd0;
                  winner_q <= 2'b00;
               end
            end
            CLR: begin
               state_q     <= LOAD;
               cnt_reset_q <= 1'b0;
               cnt_init_q  <= 1'b1;
               ctrl_q      <= rd_cfg.mode;
               val_q       <= rd_cfg.val;
            end
            LOAD: begin
               state_q <= RUN;
               tmo_q   <= 8'd0;
            end
            RUN: begin
               if (gameover) begin
                  state_q <= TALLY;
                  who_q   <= who;
               end else if (tmo_q == TMO_LAST) begin
                  state_q <= TALLY;
                  who_q   <= 2'b00;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            TALLY: begin
               sa_q <= sa_d;
               sb_q <= sb_d;
               if (end_d) begin
                  state_q  <= DONE;
                  done_q   <= 1'b1;
                  winner_q <= winner_d;
               end else begin
                  state_q     <= CLR;
                  round_q     <= round_q + 2'd1;
                  cnt_reset_q <= 1'b1;
               end
            end
            DONE: begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               cnt_reset_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cnt_reset    = cnt_reset_q;
   assign cnt_init     = cnt_init_q;
   assign cnt_ctrl     = ctrl_q;
   assign cnt_val      = val_q;
   assign busy         = busy_q;
   assign round_no     = round_q;
   assign score_a      = sa_q;
   assign score_b      = sb_q;
   assign match_done   = done_q;
   assign match_winner = winner_q;

endmodule

// File: tb/tb_m_m_round_sched.sv
// tb_m_m_round_sched: directed plus randomized match bench for m_m_round_sched.
// A match-level model tracks the table and the expected scores per round.
module tb_m_m_round_sched;

   logic       clk = 1'b0;
   logic       reset, start, cfg_we;
   logic [1:0] cfg_idx, cfg_mode;
   logic [2:0] cfg_val;
   logic       cnt_reset, cnt_init;
   logic [1:0] cnt_ctrl;
   logic [2:0] cnt_val;
   logic       gameover;
   logic [1:0] who;
   logic       busy;
   logic [1:0] round_no;
   logic [2:0] score_a, score_b;
   logic       match_done;
   logic [1:0] match_winner;

   int n_chk  = 0;
   int n_pass = 0;
   int n_done = 0;

   logic [1:0] t_mode [4];
   logic [2:0] t_val  [4];
   logic [1:0] w_seq  [4];
   int         d_seq  [4];

   m_m_round_sched dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .cfg_we       (cfg_we),
      .cfg_idx      (cfg_idx),
      .cfg_mode     (cfg_mode),
      .cfg_val      (cfg_val),
      .cnt_reset    (cnt_reset),
      .cnt_init     (cnt_init),
      .cnt_ctrl     (cnt_ctrl),
      .cnt_val      (cnt_val),
      .gameover     (gameover),
      .who          (who),
      .busy         (busy),
      .round_no     (round_no),
      .score_a      (score_a),
      .score_b      (score_b),
      .match_done   (match_done),
      .match_winner (match_winner)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (match_done === 1'b1) n_done++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_cnt_reset"}, cnt_reset, 1);
      chk({tag, "_cnt_init"}, cnt_init, 0);
      chk({tag, "_ctrl"}, cnt_ctrl, 0);
      chk({tag, "_val"}, cnt_val, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_round"}, round_no, 0);
      chk({tag, "_sa"}, score_a, 0);
      chk({tag, "_sb"}, score_b, 0);
      chk({tag, "_done"}, match_done, 0);
      chk({tag, "_winner"}, match_winner, 0);
   endtask

   task automatic write_cfg(input int idx, input int m, input int v);
      cfg_we = 1'b1;
      cfg_idx = 2'(idx);
      cfg_mode = 2'(m);
      cfg_val = 3'(v);
      tick();
      cfg_we = 1'b0;
      t_mode[idx] = 2'(m);
      t_val[idx] = 3'(v);
   endtask

   task automatic begin_match(input bit wr, input int idx, input int m,
                              input int v);
      if (wr) begin
         cfg_we = 1'b1;
         cfg_idx = 2'(idx);
         cfg_mode = 2'(m);
         cfg_val = 3'(v);
         t_mode[idx] = 2'(m);
         t_val[idx] = 3'(v);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_we = 1'b0;
   endtask

   task automatic play_match(input bit noisy, input int rst_at);
      int ea, eb, n0;
      bit fin;
      logic [1:0] w, ew;
      ea = 0;
      eb = 0;
      n0 = n_done;
      for (int r = 0; r < 4; r++) begin
         chk("clr_reset", cnt_reset, 1);
         chk("clr_init", cnt_init, 0);
         chk("clr_busy", busy, 1);
         chk("clr_round", round_no, 8'(r));
         chk("clr_done", match_done, 0);
         if (r == 0) chk("clr_winner", match_winner, 0);
         if (noisy) begin
            gameover = 1'b1;
            who = 2'b01;
         end
         tick();
         chk("load_init", cnt_init, 1);
         chk("load_reset", cnt_reset, 0);
         chk("load_ctrl", cnt_ctrl, t_mode[r]);
         chk("load_val", cnt_val, t_val[r]);
         tick();
         gameover = 1'b0;
         chk("run_init", cnt_init, 0);
         chk("run_reset", cnt_reset, 0);
         if (r == rst_at) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk_idle("midrst");
            for (int i = 0; i < 4; i++) begin
               t_mode[i] = 2'b00;
               t_val[i] = 3'b000;
            end
            return;
         end
         if (d_seq[r] < 0) begin
            repeat (254) tick();
            chk("tmo_pending", busy, 1);
            tick();
            w = 2'b00;
         end else begin
            for (int k = 0; k < d_seq[r]; k++) begin
               who = 2'($urandom);
               start = noisy && ($urandom_range(0, 2) == 0);
               cfg_we = noisy && ($urandom_range(0, 1) == 0);
               cfg_idx = 2'($urandom);
               cfg_mode = 2'($urandom);
               cfg_val = 3'($urandom);
               tick();
            end
            start = 1'b0;
            cfg_we = 1'b0;
            gameover = 1'b1;
            who = w_seq[r];
            w = w_seq[r];
            tick();
            gameover = 1'b0;
            who = 2'($urandom);
         end
         chk("tally_ctrl", cnt_ctrl, t_mode[r]);
         chk("tally_val", cnt_val, t_val[r]);
         chk("tally_sa_old", score_a, 8'(ea));
         tick();
         if (w == 2'b01 && ea < 7) ea++;
         if (w == 2'b10 && eb < 7) eb++;
         fin = (ea == 3) || (eb == 3) || (r == 3);
         chk("score_a", score_a, 8'(ea));
         chk("score_b", score_b, 8'(eb));
         chk("match_done", match_done, 8'(fin));
         if (fin) begin
            ew = (ea > eb) ? 2'b01 : (eb > ea) ? 2'b10 : 2'b11;
            chk("winner", match_winner, ew);
            chk("final_round", round_no, 8'(r));
            chk("done_busy", busy, 1);
            tick();
            chk("idle_busy", busy, 0);
            chk("idle_reset", cnt_reset, 1);
            chk("idle_done", match_done, 0);
            chk("winner_held", match_winner, ew);
            chk("done_once", 8'(n_done - n0), 1);
            repeat (3) tick();
            chk("no_more_load", cnt_init, 0);
            chk("still_held", match_winner, ew);
            break;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      cfg_we = 1'b0;
      cfg_idx = 2'b00;
      cfg_mode = 2'b00;
      cfg_val = 3'b000;
      gameover = 1'b0;
      who = 2'b00;
      for (int i = 0; i < 4; i++) begin
         t_mode[i] = 2'b00;
         t_val[i] = 3'b000;
      end
      tick();
      tick();
      chk_idle("rst");
      reset = 1'b0;
      tick();
      chk_idle("idle");

      // T1 + T3: table load ordering, A,B,B,A -> 2/2 tie
      write_cfg(0, 0, 5);
      write_cfg(1, 1, 3);
      write_cfg(2, 2, 2);
      write_cfg(3, 3, 6);
      w_seq = '{2'b01, 2'b10, 2'b10, 2'b01};
      d_seq = '{3, 0, 7, 1};
      begin_match(0, 0, 0, 0);
      play_match(0, -1);

      // T2: A wins three straight, round 3 never loaded
      w_seq = '{2'b01, 2'b01, 2'b01, 2'b10};
      d_seq = '{2, 5, 0, 0};
      begin_match(0, 0, 0, 0);
      play_match(1, -1);

      // T4: round 0 times out as a draw
      w_seq = '{2'b01, 2'b10, 2'b11, 2'b10};
      d_seq = '{-1, 1, 2, 0};
      begin_match(0, 0, 0, 0);
      play_match(0, -1);

      // T5: reset in RUN of round 1 clears the table too
      w_seq = '{2'b10, 2'b01, 2'b01, 2'b01};
      d_seq = '{1, 1, 1, 1};
      begin_match(0, 0, 0, 0);
      play_match(0, 1);
      w_seq = '{2'b00, 2'b10, 2'b01, 2'b10};
      d_seq = '{0, 4, 2, 3};
      begin_match(0, 0, 0, 0);
      play_match(0, -1);

      // T6: same-cycle write and start, writes while busy ignored
      write_cfg(1, 1, 3);
      w_seq = '{2'b01, 2'b11, 2'b10, 2'b01};
      d_seq = '{6, 8, 5, 9};
      begin_match(1, 0, 3, 7);
      play_match(1, -1);

      for (int m = 0; m < 8; m++) begin
         repeat ($urandom_range(0, 4)) begin
            write_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 7)));
         end
         for (int i = 0; i < 4; i++) begin
            w_seq[i] = 2'($urandom);
            d_seq[i] = ($urandom_range(0, 9) == 0) ? -1
                                                  : int'($urandom_range(0, 12));
         end
         begin_match(0, 0, 0, 0);
         play_match(bit'($urandom_range(0, 1)), -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
